// File: rtl/bus_pkg.sv
// Shared definitions for the 3-master Req/Ack bus: state encoding,
// default widths and master index constants used by the arbiter wiring.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 2;

  localparam int NUM_MASTERS = 3;
  localparam int MASTER_0    = 0;
  localparam int MASTER_1    = 1;
  localparam int MASTER_2    = 2;

endpackage

// File: rtl/bus_req_timer.sv
// Saturating wait counter for the request phase. expired is high while
// the count sits at TIMEOUT-1; clear has priority over enable.
module bus_req_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count consecutive ungranted request cycles, holding at LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/bus_master_port.sv
// Master-side initiator for the shared Req/Ack bus. Accepts one write
// burst command, requests the bus, streams beats while ack holds,
// survives preemption (ack dropping mid-burst) and aborts on a grant
// timeout. fsm_state exposes the controller state for debug.
//
// Handshakes: a local command transfers on a cycle where cmd_valid and
// cmd_ready are both high; a write beat transfers on a cycle where
// wr_valid and wr_ready are both high. Neither valid may depend on the
// matching ready. On the bus side a beat is written exactly when bus_we
// is high, which is the same cycle the local beat is consumed.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              req,
  input  logic              ack,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              done,
  output logic              timeout_err,
  output state_t            fsm_state
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  // The timer restarts on every new command and on every preemption, so
  // the timeout bounds each individual wait for a grant.
  assign timer_clear  = ((state == ST_IDLE) && cmd_valid) ||
                        ((state == ST_XFER) && !ack);
  assign timer_enable = (state == ST_REQ) && !ack;

  bus_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Combinational bus drive: only a granted XFER cycle with data writes.
  assign cmd_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_XFER) && ack && wr_valid;
  assign bus_we    = wr_ready;
  assign bus_addr  = bus_we ? (addr_q + ADDR_W'(beat)) : '0;
  assign bus_data  = bus_we ? wr_data : '0;
  assign fsm_state = state;

  // Controller FSM with registered req/done/timeout_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      beat        <= '0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            beat   <= '0;
            req    <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack) begin
            state <= ST_XFER;
          end else if (timer_expired) begin
            // Give up: remaining beats are discarded.
            timeout_err <= 1'b1;
            req         <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (!ack) begin
            // Preempted: keep req and beat, resume at base+beat later.
            state <= ST_REQ;
          end else if (wr_valid) begin
            beat <= beat + LEN_W'(1);
            if (beat == len_q) begin
              req   <= 1'b0;
              done  <= 1'b1;
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          // One guaranteed cycle with req low lets the arbiter rotate.
          state <= ST_IDLE;
        end
        default: begin
          req   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: nominal burst, grant timeout,
// preemption, data stall, address wrap and asynchronous reset mid-burst.
module tb_bus_master_port;
  import bus_pkg::*;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [1:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       req;
  logic       ack;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_data;
  logic       done;
  logic       timeout_err;
  state_t     fsm_state;

  bus_master_port #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .LEN_W   (2),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .req         (req),
    .ack         (ack),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .done        (done),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected bus writes as {addr, data}
  logic [15:0] exp_q[$];
  int          n_compared;
  int          n_mismatched;
  int          n_writes;

  logic [7:0] data_tab[4];
  int         data_idx;

  // Snapshot of DUT outputs taken at the falling edge of the last tick
  logic       s_req, s_done, s_to, s_cr, s_we, s_wr;
  logic [7:0] s_addr, s_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard writes), then step past posedge
  // and advance the local write-data source if a beat was consumed.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_req  = req;
    s_done = done;
    s_to   = timeout_err;
    s_cr   = cmd_ready;
    s_we   = bus_we;
    s_wr   = wr_ready;
    s_addr = bus_addr;
    s_data = bus_data;
    if (bus_we) begin
      n_writes++;
      e = (exp_q.size() != 0) ? {16'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
      check_eq("bus_write", {16'h0, bus_addr, bus_data}, e);
    end
    @(posedge clk);
    #1;
    if (s_wr && data_idx < 3) data_idx++;
    wr_data = data_tab[data_idx];
  endtask

  // Present a command for one cycle (IDLE accepts it).
  task automatic start(input logic [7:0] a, input logic [1:0] l,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    data_tab[0] = d0; data_tab[1] = d1; data_tab[2] = d2; data_tab[3] = d3;
    data_idx  = 0;
    wr_data   = d0;
    n_writes  = 0;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    check_eq("cmd_ready_at_accept", s_cr, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_burst(input string tag, input int n_exp);
    ack = 1'b0;
    wr_valid = 1'b0;
    tick();
    check_eq({tag, "_done"}, s_done, 1);
    check_eq({tag, "_req_released"}, s_req, 0);
    tick();
    check_eq({tag, "_done_pulse"}, s_done, 0);
    check_eq({tag, "_cmd_ready"}, s_cr, 1);
    check_eq({tag, "_writes"}, n_writes, n_exp);
    check_eq({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int  n_req;
    bit  saw_to;
    n_compared = 0; n_mismatched = 0; n_writes = 0; data_idx = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; ack = 1'b0;
    for (int i = 0; i < 4; i++) data_tab[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req", req, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_bus_we", bus_we, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_data", bus_data, 0);
    check_eq("rst_state", fsm_state, ST_IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Nominal burst: 0x10, 4 beats A0..A3, ack one cycle after req
    exp_q.push_back(16'h10A0); exp_q.push_back(16'h11A1);
    exp_q.push_back(16'h12A2); exp_q.push_back(16'h13A3);
    start(8'h10, 2'd3, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    tick();
    check_eq("nom_req_latency", s_req, 1);
    check_eq("nom_cmd_ready_busy", s_cr, 0);
    ack = 1'b1; wr_valid = 1'b1;
    tick();
    check_eq("nom_no_we_in_req", s_we, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("nom_we_consecutive", s_we, 1);
      check_eq("nom_req_held", s_req, 1);
    end
    finish_burst("nom", 4);

    // No grant: timeout after 15 REQ cycles
    start(8'h55, 2'd2, 8'h01, 8'h02, 8'h03, 8'h04);
    ack = 1'b0; wr_valid = 1'b1;
    n_req = 0; saw_to = 1'b0;
    for (int i = 0; i < 40 && !saw_to; i++) begin
      tick();
      if (s_to) begin
        saw_to = 1'b1;
        check_eq("to_req_dropped", s_req, 0);
        check_eq("to_cmd_ready", s_cr, 1);
      end else if (s_req) begin
        n_req++;
      end
    end
    check_eq("to_seen", saw_to, 1);
    check_eq("to_req_cycles", n_req, 15);
    tick();
    check_eq("to_pulse_one_cycle", s_to, 0);
    check_eq("to_no_writes", n_writes, 0);
    wr_valid = 1'b0;

    // Preemption after 2 beats for 3 cycles
    exp_q.push_back(16'h40B0); exp_q.push_back(16'h41B1);
    exp_q.push_back(16'h42B2); exp_q.push_back(16'h43B3);
    start(8'h40, 2'd3, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    ack = 1'b1; wr_valid = 1'b1;
    tick();
    tick();
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("pre_no_we", s_we, 0);
      check_eq("pre_req_held", s_req, 1);
      check_eq("pre_addr_zero", s_addr, 0);
      check_eq("pre_data_zero", s_data, 0);
    end
    ack = 1'b1;
    tick();
    check_eq("pre_regrant_no_we", s_we, 0);
    tick();
    check_eq("pre_resume_addr", s_addr, 8'h42);
    tick();
    finish_burst("pre", 4);

    // Data stall: wr_valid low 2 cycles after 2 beats
    exp_q.push_back(16'h80C0); exp_q.push_back(16'h81C1);
    exp_q.push_back(16'h82C2); exp_q.push_back(16'h83C3);
    start(8'h80, 2'd3, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    ack = 1'b1; wr_valid = 1'b1;
    tick();
    tick();
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("stall_wr_ready", s_wr, 0);
      check_eq("stall_no_we", s_we, 0);
      check_eq("stall_req_held", s_req, 1);
    end
    wr_valid = 1'b1;
    tick();
    check_eq("stall_resume_addr", s_addr, 8'h82);
    tick();
    finish_burst("stall", 4);

    // Address wrap: FE, FF, 00, 01
    exp_q.push_back(16'hFED0); exp_q.push_back(16'hFFD1);
    exp_q.push_back(16'h00D2); exp_q.push_back(16'h01D3);
    start(8'hFE, 2'd3, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    ack = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    finish_burst("wrap", 4);

    // Asynchronous reset mid-XFER after beat 1
    exp_q.push_back(16'h20E0);
    start(8'h20, 2'd3, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    ack = 1'b1; wr_valid = 1'b1;
    tick();
    tick();
    check_eq("arst_one_write", n_writes, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_req", req, 0);
    check_eq("arst_bus_we", bus_we, 0);
    check_eq("arst_bus_addr", bus_addr, 0);
    check_eq("arst_cmd_ready", cmd_ready, 1);
    ack = 1'b0; wr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    check_eq("arst_idle_req", s_req, 0);
    check_eq("arst_exp_left", exp_q.size(), 0);

    // New command after reset completes normally (2 beats)
    exp_q.push_back(16'h30F0); exp_q.push_back(16'h31F1);
    start(8'h30, 2'd1, 8'hF0, 8'hF1, 8'hF2, 8'hF3);
    ack = 1'b1; wr_valid = 1'b1;
    tick();
    tick();
    tick();
    finish_burst("post_rst", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
